mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-port
// synchronous RAM. Port A is instruction fetch, port B the data stage.
// Each grant takes IDLE -> ISSUE -> RESP, or IDLE -> RESP for a
// misaligned access. The winner's request is latched, so the requester
// may drop or change its inputs once it has been granted.
//
// Handshake: a requester raises req with we/addr/wdata stable and keeps
// req high until it sees a one-cycle ack. The ack cycle also carries err.
// Read data appears on rdata in the cycle after ack and is held until the
// next aligned read by the same port.

module mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // port A (instruction fetch)
  input  logic              a_req,
  input  logic              a_we,
  input  logic [31:0]       a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  // port B (data memory stage)
  input  logic              b_req,
  input  logic              b_we,
  input  logic [31:0]       b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,
  // RAM side
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  // observability: current FSM state (0 IDLE, 1 ISSUE, 2 RESP)
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched transaction. r_id: 0 = port A, 1 = port B.
  logic              r_id;
  logic              r_we;
  logic [ADDR_W+1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  // Round-robin pointer: 1 = port B has priority on a collision.
  logic              r_prio_b;

  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;

  // Arbitration and selected-request signals.
  logic              w_any_req;
  logic              w_grant_b;
  logic              w_sel_we;
  logic [ADDR_W+1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_mis;
  logic              w_mis;
  logic              w_in_resp;
  logic              w_load_rdata;

  // Address bits above the RAM window are ignored, so the space aliases.
  logic              w_unused_addr;
  assign w_unused_addr = ^{a_addr[31:ADDR_W+2], b_addr[31:ADDR_W+2]};

  // Pick the winner: a lone requester always wins, a collision goes to
  // whichever port the pointer favours.
  always_comb begin
    w_any_req   = a_req | b_req;
    w_grant_b   = b_req & (~a_req | r_prio_b);
    w_sel_we    = w_grant_b ? b_we : a_we;
    w_sel_addr  = w_grant_b ? b_addr[ADDR_W+1:0] : a_addr[ADDR_W+1:0];
    w_sel_wdata = w_grant_b ? b_wdata : a_wdata;
    w_sel_mis   = (w_sel_addr[1:0] != 2'b00);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: misaligned accesses skip the RAM cycle entirely.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = w_sel_mis ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_RESP;
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture the winner's request when leaving IDLE; held for the whole grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == ST_IDLE && w_any_req) begin
      r_id    <= w_grant_b;
      r_we    <= w_sel_we;
      r_addr  <= w_sel_addr;
      r_wdata <= w_sel_wdata;
    end
  end

  // Hand priority to the other port whenever a grant completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio_b <= 1'b1;
    end else if (r_state == ST_RESP) begin
      r_prio_b <= ~r_id;
    end
  end

  // Decode of the latched transaction.
  always_comb begin
    w_mis        = (r_addr[1:0] != 2'b00);
    w_in_resp    = (r_state == ST_RESP);
    w_load_rdata = w_in_resp & ~r_we & ~w_mis;
  end

  // Read data registers: only the winner's register loads, and only for an
  // aligned read, on the edge that leaves RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else if (w_load_rdata) begin
      if (r_id) begin
        r_b_rdata <= ram_dout;
      end else begin
        r_a_rdata <= ram_dout;
      end
    end
  end

  // Output decode. RAM address/data follow the latch in every state; the
  // write strobe is confined to ISSUE, which misaligned accesses never reach.
  always_comb begin
    ram_we    = (r_state == ST_ISSUE) & r_we & ~w_mis;
    ram_addr  = r_addr[ADDR_W+1:2];
    ram_din   = r_wdata;
    a_ack     = w_in_resp & ~r_id;
    b_ack     = w_in_resp & r_id;
    a_err     = w_in_resp & ~r_id & w_mis;
    b_err     = w_in_resp & r_id & w_mis;
    a_rdata   = r_a_rdata;
    b_rdata   = r_b_rdata;
    dbg_state = r_state;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table of single-port transactions plus
// hand-written sequences for mid-transaction input changes, reset during
// ISSUE and continuous contention.

module tb_mem_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              a_req = 1'b0, a_we = 1'b0;
  logic [31:0]       a_addr = '0;
  logic [DATA_W-1:0] a_wdata = '0;
  logic              a_ack, a_err;
  logic [DATA_W-1:0] a_rdata;
  logic              b_req = 1'b0, b_we = 1'b0;
  logic [31:0]       b_addr = '0;
  logic [DATA_W-1:0] b_wdata = '0;
  logic              b_ack, b_err;
  logic [DATA_W-1:0] b_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout = '0;
  logic [1:0]        dbg_state;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .dbg_state(dbg_state)
  );

  // Synchronous RAM: one-cycle read latency.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic              grant_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_a_ack"}, a_ack, 0);
    chk({tag, "_b_ack"}, b_ack, 0);
    chk({tag, "_a_err"}, a_err, 0);
    chk({tag, "_b_err"}, b_err, 0);
    chk({tag, "_a_rdata"}, a_rdata, 0);
    chk({tag, "_b_rdata"}, b_rdata, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_din"}, ram_din, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              port_b;
    logic              we;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    int                exp_lat;
    logic              exp_err;
    int                exp_wecnt;
    logic [ADDR_W-1:0] exp_ram_addr;
    logic [31:0]       exp_rdata;   // winner's rdata after the transaction
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs[NVEC];
  logic [DATA_W-1:0] exp_a_rd = '0;
  logic [DATA_W-1:0] exp_b_rd = '0;

  // ---------------- driver ----------------
  task automatic run_vec(input vec_t v, input int idx);
    int ack_n;
    int we_cnt;
    int other_ack;
    logic err_s;
    logic [ADDR_W-1:0] ra;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(posedge clk); #1;
    if (v.port_b) begin
      b_req = 1'b1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata;
    end else begin
      a_req = 1'b1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
    end
    ack_n = 0; we_cnt = 0; other_ack = 0; err_s = 1'b0; ra = '0;
    for (int n = 1; n <= 6 && ack_n == 0; n++) begin
      @(negedge clk);
      if (ram_we) we_cnt++;
      if (v.port_b ? a_ack : b_ack) other_ack++;
      if (v.port_b ? b_ack : a_ack) begin
        ack_n = n;
        err_s = v.port_b ? b_err : a_err;
        ra = ram_addr;
      end
    end
    @(posedge clk); #1;
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    if (v.port_b) exp_b_rd = v.exp_rdata;
    else          exp_a_rd = v.exp_rdata;
    exp_q.push_back(v.exp_rdata);
    chk({tag, "_latency"}, ack_n, v.exp_lat);
    chk({tag, "_err"}, err_s, v.exp_err);
    chk({tag, "_ram_we_cycles"}, we_cnt, v.exp_wecnt);
    chk({tag, "_ram_addr"}, ra, v.exp_ram_addr);
    chk({tag, "_other_ack"}, other_ack, 0);
    chk({tag, "_rdata"}, v.port_b ? b_rdata : a_rdata, exp_q.pop_front());
    chk({tag, "_a_rdata_hold"}, a_rdata, exp_a_rd);
    chk({tag, "_b_rdata_hold"}, b_rdata, exp_b_rd);
    chk({tag, "_idle"}, dbg_state, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    int acks;
    int last_n;
    logic got_b;

    //            port we  addr          wdata         lat err wec raddr    rdata
    vecs[0]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 3, 1'b0, 1, 10'h004, 32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        3, 1'b0, 0, 10'h004, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b0, 32'h0000_0006, 32'h0,        2, 1'b1, 0, 10'h001, 32'h0000_0000};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_1004, 32'h12345678, 3, 1'b0, 1, 10'h001, 32'h0000_0000};
    vecs[4]  = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,        3, 1'b0, 0, 10'h001, 32'h12345678};
    vecs[5]  = '{1'b1, 1'b1, 32'h0000_3FFC, 32'hCAFEF00D, 3, 1'b0, 1, 10'h3FF, 32'hDEADBEEF};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,        3, 1'b0, 0, 10'h3FF, 32'hCAFEF00D};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0013, 32'h11111111, 2, 1'b1, 0, 10'h004, 32'hCAFEF00D};
    vecs[8]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,        3, 1'b0, 0, 10'h004, 32'hDEADBEEF};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hA5A5A5A5, 3, 1'b0, 1, 10'h000, 32'hDEADBEEF};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,        3, 1'b0, 0, 10'h000, 32'hA5A5A5A5};

    // Reset state.
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    // Table-driven single-port transactions.
    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // Requester drops req and changes inputs while its read is in flight.
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0000_0004;
    @(posedge clk); #1;
    a_req = 1'b0; a_we = 1'b1; a_addr = 32'h0000_0008; a_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("mid_issue_state", dbg_state, 1);
    chk("mid_ram_we", ram_we, 0);
    chk("mid_ram_addr", ram_addr, 1);
    @(negedge clk);
    chk("mid_a_ack", a_ack, 1);
    chk("mid_a_err", a_err, 0);
    @(negedge clk);
    chk("mid_a_rdata", a_rdata, 32'h12345678);
    chk("mid_back_idle", dbg_state, 0);
    a_we = 1'b0;

    // Reset asserted in the ISSUE cycle of a B write.
    @(posedge clk); #1;
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h0000_0020; b_wdata = 32'h7777_7777;
    @(negedge clk);
    @(negedge clk);
    chk("rst_issue_state", dbg_state, 1);
    chk("rst_issue_ram_we", ram_we, 1);
    rst_n = 1'b0;
    b_req = 1'b0;
    #1;
    chk_outputs_zero("rst_mid");
    // Both ports request continuously from reset onward.
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0000_0010;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h0000_0004;
    repeat (2) @(negedge clk);
    chk("rst_hold_b_ack", b_ack, 0);
    chk("rst_hold_state", dbg_state, 0);
    rst_n = 1'b1;

    grant_q.push_back(1'b1);
    grant_q.push_back(1'b0);
    grant_q.push_back(1'b1);
    grant_q.push_back(1'b0);
    acks = 0;
    last_n = 0;
    for (int n = 1; n <= 20 && acks < 4; n++) begin
      @(negedge clk);
      chk("arb_one_ack", a_ack & b_ack, 0);
      if (a_ack || b_ack) begin
        got_b = b_ack;
        chk($sformatf("arb_grant%0d", acks), got_b, grant_q.pop_front());
        chk($sformatf("arb_spacing%0d", acks), n - last_n, (acks == 0) ? 2 : 3);
        last_n = n;
        acks++;
      end
    end
    chk("arb_ack_count", acks, 4);
    @(posedge clk); #1;
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    chk("arb_a_rdata", a_rdata, 32'hDEADBEEF);
    chk("arb_b_rdata", b_rdata, 32'h12345678);
    chk("arb_idle", dbg_state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
